intr_request_ctrl: RTL and testbench
====================================

# intr_request_ctrl

Request-side companion to the 27-channel interrupt priority controller: latches event pulses from 9 channels at 3 priority levels (A > B > C) into pending registers and drives the controller's enable and active-low request vectors. It takes the controller's grant back (PA/PB/PC plus the 4-bit channel code), presents one interrupt at a time to the CPU with a valid/ack handshake, and clears the serviced pending bit on acknowledge. It sits between peripheral event sources and the combinational priority controller.

## Interface

- No parameters; widths are fixed at 9 channels × 3 levels.
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ev_a / ev_b / ev_c  in  9 each  one-cycle event pulses, level A / B / C; bit k is channel k
- en  in  9  per-channel enable
- E  out  9  registered copy of en, to controller enable
- A / B / C  out  9 each  active-low requests: ~pend_a / ~pend_b / ~pend_c
- PA / PB / PC  in  1 each  controller level grants (combinational from E, A, B, C)
- Chan  in  4  controller channel code; captured opaque, not decoded
- irq_valid  out  1  interrupt presented to CPU
- irq_level  out  2  1 = A, 2 = B, 3 = C; 0 when idle
- irq_chan  out  4  winning channel index, 0..8
- irq_code  out  4  Chan captured at grant
- irq_ack  in  1  CPU acknowledge; effective only when irq_valid = 1
- drop_cnt  out  8  saturating count of events lost to an already-pending bit

## Operation

- Pending: pend_x[k] sets on ev_x[k]. It is latched whether or not en[k] is set. The enable only gates the request through E.
- Dropped events: if ev_x[k] = 1 while pend_x[k] = 1 and that bit is not being cleared this cycle, drop_cnt increments by 1 per lost bit-event. With multiple lost bits in one cycle, add the popcount. drop_cnt saturates at 255.
- Simultaneous set and clear of the same bit: set wins, bit stays 1, no drop counted.
- Winner: the level is the first asserted of PA, PB, PC (A highest). The channel is the highest index k with pend_level[k] & E[k].
- FSM states:
  - IDLE
    - Grant present (any P asserted and winner exists): capture level, channel and Chan into irq_level / irq_chan / irq_code. Set irq_valid. Go to HOLD.
    - P asserted but no matching winner: treat as no grant, stay IDLE.
  - HOLD
    - irq_valid held. irq_level, irq_chan, irq_code are frozen.
    - Changes to PA/PB/PC/Chan/en are ignored, including a higher-priority event arriving.
    - On irq_ack: clear pend_{irq_level}[irq_chan], drop irq_valid, zero irq_level / irq_chan / irq_code. Go to SETTLE.
  - SETTLE: one cycle to let the registered A/B/C and the combinational grant update, then IDLE.
- irq_ack in IDLE or SETTLE is ignored.
- Reset values: pend_* = 0, so A = B = C = 9'h1FF; E = 0; irq_valid = 0; irq_level = 0; irq_chan = 0; irq_code = 0; drop_cnt = 0; state IDLE.
- Reset asserted mid-HOLD: all of the above apply at that edge. The pending interrupt is discarded, no ack is needed.

## Timing

- Event at edge n: pend and A/B/C updated after edge n. E follows en with 1 cycle latency.
- Grant sampled at edge n+1 in IDLE, so irq_valid is high after edge n+1 (2 edges from event to valid, with the enable already stable).
- Ack sampled at edge m: irq_valid low after m. SETTLE occupies m..m+1. Earliest next irq_valid is after edge m+2.
- irq_valid, once set, stays high until an ack edge or reset. No retraction.

## Test plan

- Reset, then en = 9'h1FF, ev_a[3] pulse → 2 edges later irq_valid = 1, irq_level = 1, irq_chan = 3, A = 9'h1F7. After ack, A = 9'h1FF and irq_valid = 0 on the next cycle.
- Same cycle, ev_c[8] and ev_b[0] → irq_level = 2, irq_chan = 0 first. After ack + SETTLE, irq_level = 3, irq_chan = 8.
- ev_a[5] and ev_a[2] together → irq_chan = 5 first, then 2. irq_code matches the Chan value driven at each capture edge.
- en = 0, ev_b[4] → no irq_valid for 10 cycles, B[4] = 0. Set en[4] → irq_valid 2 edges later with level 2, chan 4.
- ev_a[1] pulsed 300 times while held in HOLD on another channel → drop_cnt = 255 and pend_a[1] = 1. Pulse ev_a[1] on the clear edge of chan 1 → bit stays set, drop_cnt is unchanged.
- rst asserted while in HOLD → next cycle all outputs at reset values. irq_ack afterwards has no effect.

Source files
------------

// File: rtl/intr_request_ctrl_if.sv
// CPU-facing interrupt handshake bundle between intr_request_ctrl and the CPU.
// Latency: wires only, no state.
// Backpressure: irq_valid holds until the CPU raises irq_ack, which is the only stall mechanism.
// Ports: irq_valid/irq_level/irq_chan/irq_code (request side -> CPU), irq_ack (CPU -> request side).
interface intr_request_ctrl_if;
    logic       irq_valid;
    logic [1:0] irq_level;   // 1 = A, 2 = B, 3 = C, 0 = idle
    logic [3:0] irq_chan;    // winning channel 0..8
    logic [3:0] irq_code;    // controller channel code captured at grant
    logic       irq_ack;

    modport master (
        output irq_valid,
        output irq_level,
        output irq_chan,
        output irq_code,
        input  irq_ack
    );

    modport slave (
        input  irq_valid,
        input  irq_level,
        input  irq_chan,
        input  irq_code,
        output irq_ack
    );
endinterface

// File: rtl/intr_request_ctrl.sv
// Latches 9x3 event pulses into pending bits, feeds the priority controller, presents one irq to the CPU.
// Latency: event -> A/B/C 1 edge; en -> E 1 edge; event -> irq_valid 2 edges; ack -> next irq_valid 2 edges.
// Backpressure: one interrupt in flight; it is held frozen until irq_ack, events keep latching meanwhile.
// Ports: clk, rst (sync, active-high); ev_a/ev_b/ev_c event pulses; en enable; E/A/B/C to controller
//        (A/B/C active-low); PA/PB/PC/Chan grant from controller; irq (master) CPU handshake; drop_cnt.
module intr_request_ctrl (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8:0]                 ev_a,
    input  logic [8:0]                 ev_b,
    input  logic [8:0]                 ev_c,
    input  logic [8:0]                 en,
    output logic [8:0]                 E,
    output logic [8:0]                 A,
    output logic [8:0]                 B,
    output logic [8:0]                 C,
    input  logic                       PA,
    input  logic                       PB,
    input  logic                       PC,
    input  logic [3:0]                 Chan,
    output logic [7:0]                 drop_cnt,
    intr_request_ctrl_if.master        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] pend_a_q, pend_a_d;
    logic [8:0] pend_b_q, pend_b_d;
    logic [8:0] pend_c_q, pend_c_d;
    logic [8:0] e_q, e_d;
    logic [1:0] irq_level_q, irq_level_d;
    logic [3:0] irq_chan_q, irq_chan_d;
    logic [3:0] irq_code_q, irq_code_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    logic [1:0]  grant_lvl;
    logic [8:0]  cand;
    logic [3:0]  win_chan;
    logic [8:0]  chan_mask;
    logic [8:0]  clr_a, clr_b, clr_c;
    logic [26:0] lost;
    logic [4:0]  lost_cnt;
    logic [8:0]  drop_sum;

    always_comb begin
        state_d     = state_q;
        irq_level_d = irq_level_q;
        irq_chan_d  = irq_chan_q;
        irq_code_d  = irq_code_q;
        clr_a       = '0;
        clr_b       = '0;
        clr_c       = '0;
        e_d         = en;

        // Level is the first asserted grant line; the channel is then picked
        // locally from our own pending/enable so it always names a real bit.
        if (PA)      grant_lvl = 2'd1;
        else if (PB) grant_lvl = 2'd2;
        else if (PC) grant_lvl = 2'd3;
        else         grant_lvl = 2'd0;

        case (grant_lvl)
            2'd1:    cand = pend_a_q & e_q;
            2'd2:    cand = pend_b_q & e_q;
            2'd3:    cand = pend_c_q & e_q;
            default: cand = '0;
        endcase

        win_chan = '0;
        for (int k = 0; k < 9; k++) begin
            if (cand[k]) win_chan = 4'(k);   // ascending scan: highest index wins
        end

        chan_mask = 9'd1 << irq_chan_q;

        case (state_q)
            ST_IDLE: begin
                // A grant line with no matching enabled pending bit is spurious.
                if (grant_lvl != 2'd0 && |cand) begin
                    irq_level_d = grant_lvl;
                    irq_chan_d  = win_chan;
                    irq_code_d  = Chan;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (irq.irq_ack) begin
                    case (irq_level_q)
                        2'd1:    clr_a = chan_mask;
                        2'd2:    clr_b = chan_mask;
                        2'd3:    clr_c = chan_mask;
                        default: ;
                    endcase
                    irq_level_d = '0;
                    irq_chan_d  = '0;
                    irq_code_d  = '0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Lets A/B/C and the controller's grant reflect the cleared bit.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Set dominates clear for the same bit.
        pend_a_d = (pend_a_q & ~clr_a) | ev_a;
        pend_b_d = (pend_b_q & ~clr_b) | ev_b;
        pend_c_d = (pend_c_q & ~clr_c) | ev_c;

        // An event is lost only when it lands on a bit that stays pending anyway.
        lost = {ev_a & pend_a_q & ~clr_a,
                ev_b & pend_b_q & ~clr_b,
                ev_c & pend_c_q & ~clr_c};
        lost_cnt = '0;
        for (int k = 0; k < 27; k++) begin
            lost_cnt = lost_cnt + 5'(lost[k]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + {4'b0, lost_cnt};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_a_q    <= '0;
            pend_b_q    <= '0;
            pend_c_q    <= '0;
            e_q         <= '0;
            irq_level_q <= '0;
            irq_chan_q  <= '0;
            irq_code_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            pend_c_q    <= pend_c_d;
            e_q         <= e_d;
            irq_level_q <= irq_level_d;
            irq_chan_q  <= irq_chan_d;
            irq_code_q  <= irq_code_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign E             = e_q;
    assign A             = ~pend_a_q;
    assign B             = ~pend_b_q;
    assign C             = ~pend_c_q;
    assign drop_cnt      = drop_cnt_q;
    assign irq.irq_valid = (state_q == ST_HOLD);
    assign irq.irq_level = irq_level_q;
    assign irq.irq_chan  = irq_chan_q;
    assign irq.irq_code  = irq_code_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Bench for intr_request_ctrl: directed scenarios plus random traffic against a behavioural model.
// Latency: n/a.
// Backpressure: the bench plays both the priority controller and the CPU acknowledging irqs.
module tb_intr_request_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] ev_a, ev_b, ev_c, en;
    logic [8:0] E, A, B, C;
    logic       PA, PB, PC;
    logic [3:0] Chan;
    logic [7:0] drop_cnt;
    logic [2:0] spur;   // forces a grant line with no real request behind it

    intr_request_ctrl_if irq_if ();

    intr_request_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ev_a     (ev_a),
        .ev_b     (ev_b),
        .ev_c     (ev_c),
        .en       (en),
        .E        (E),
        .A        (A),
        .B        (B),
        .C        (C),
        .PA       (PA),
        .PB       (PB),
        .PC       (PC),
        .Chan     (Chan),
        .drop_cnt (drop_cnt),
        .irq      (irq_if)
    );

    // Stand-in for the combinational priority controller.
    always_comb begin
        PA = (|(E & ~A)) | spur[0];
        PB = (|(E & ~B)) | spur[1];
        PC = (|(E & ~C)) | spur[2];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending sets per level, one in-flight interrupt record.
    logic [8:0] m_pend [3];
    logic [8:0] m_e;
    bit         m_busy, m_settle;
    int         m_level, m_chan, m_code, m_drop;

    task automatic model_edge();
        logic [8:0] ev [3];
        logic [8:0] clr [3];
        int g_lvl, g_chan;
        bit ack_now;
        ev[0] = ev_a; ev[1] = ev_b; ev[2] = ev_c;
        if (rst) begin
            for (int l = 0; l < 3; l++) m_pend[l] = '0;
            m_e = '0; m_busy = 0; m_settle = 0;
            m_level = 0; m_chan = 0; m_code = 0; m_drop = 0;
            return;
        end
        for (int l = 0; l < 3; l++) clr[l] = '0;
        ack_now = m_busy && (irq_if.irq_ack === 1'b1);
        if (ack_now) clr[m_level-1][m_chan] = 1'b1;

        g_lvl = 0; g_chan = -1;
        if (!m_busy && !m_settle) begin
            for (int l = 0; l < 3; l++)
                if (g_lvl == 0 && ((|(m_pend[l] & m_e)) || spur[l])) g_lvl = l + 1;
            if (g_lvl != 0)
                for (int k = 0; k < 9; k++)
                    if (m_pend[g_lvl-1][k] && m_e[k]) g_chan = k;
        end

        for (int l = 0; l < 3; l++)
            for (int k = 0; k < 9; k++)
                if (ev[l][k] && m_pend[l][k] && !clr[l][k] && m_drop < 255) m_drop++;
        for (int l = 0; l < 3; l++) m_pend[l] = (m_pend[l] & ~clr[l]) | ev[l];
        m_e = en;

        if (ack_now) begin
            m_busy = 0; m_settle = 1; m_level = 0; m_chan = 0; m_code = 0;
        end else if (m_settle) begin
            m_settle = 0;
        end else if (!m_busy && g_chan >= 0) begin
            m_busy = 1; m_level = g_lvl; m_chan = g_chan; m_code = int'(Chan);
        end
    endtask

    task automatic tick();
        logic [8:0] ma, mb, mc;
        @(posedge clk);
        model_edge();
        #1;
        ma = ~m_pend[0]; mb = ~m_pend[1]; mc = ~m_pend[2];
        chk("irq_valid", irq_if.irq_valid, m_busy);
        chk("irq_level", irq_if.irq_level, m_level);
        chk("irq_chan",  irq_if.irq_chan,  m_chan);
        chk("irq_code",  irq_if.irq_code,  m_code);
        chk("E",         E,                m_e);
        chk("A",         A,                ma);
        chk("B",         B,                mb);
        chk("C",         C,                mc);
        chk("drop_cnt",  drop_cnt,         m_drop);
    endtask

    task automatic ack_and_settle();
        irq_if.irq_ack = 1'b1;
        tick();
        irq_if.irq_ack = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; ev_a = '0; ev_b = '0; ev_c = '0; en = '0;
        Chan = '0; spur = '0; irq_if.irq_ack = 1'b0;
        tick(); tick();
        chk("rst_valid", irq_if.irq_valid, 0);
        chk("rst_A", A, 9'h1FF);
        chk("rst_E", E, 9'h000);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // Single A event on channel 3.
        en = 9'h1FF; Chan = 4'h5; tick();
        ev_a = 9'h008; tick(); ev_a = '0;
        chk("t1_A_pend", A, 9'h1F7);
        tick();
        chk("t1_valid", irq_if.irq_valid, 1);
        chk("t1_level", irq_if.irq_level, 1);
        chk("t1_chan", irq_if.irq_chan, 3);
        chk("t1_code", irq_if.irq_code, 5);
        irq_if.irq_ack = 1'b1; tick(); irq_if.irq_ack = 1'b0;
        chk("t1_valid_after_ack", irq_if.irq_valid, 0);
        chk("t1_A_clear", A, 9'h1FF);
        tick();

        // B beats C.
        ev_c = 9'h100; ev_b = 9'h001; tick(); ev_c = '0; ev_b = '0;
        tick();
        chk("t2_level_b", irq_if.irq_level, 2);
        chk("t2_chan_0", irq_if.irq_chan, 0);
        ack_and_settle(); tick();
        chk("t2_level_c", irq_if.irq_level, 3);
        chk("t2_chan_8", irq_if.irq_chan, 8);
        ack_and_settle();

        // Two A channels: higher index first, code follows Chan at capture.
        Chan = 4'hA; ev_a = 9'h024; tick(); ev_a = '0;
        tick();
        chk("t3_chan_5", irq_if.irq_chan, 5);
        chk("t3_code_a", irq_if.irq_code, 4'hA);
        Chan = 4'h6;
        ack_and_settle(); tick();
        chk("t3_chan_2", irq_if.irq_chan, 2);
        chk("t3_code_6", irq_if.irq_code, 4'h6);
        ack_and_settle();

        // Disabled channel latches but never requests until enabled.
        en = 9'h000; tick();
        ev_b = 9'h010; tick(); ev_b = '0;
        repeat (10) tick();
        chk("t4_no_valid", irq_if.irq_valid, 0);
        chk("t4_B_pend", B, 9'h1EF);
        en = 9'h010; tick(); tick();
        chk("t4_valid", irq_if.irq_valid, 1);
        chk("t4_level", irq_if.irq_level, 2);
        chk("t4_chan", irq_if.irq_chan, 4);
        ack_and_settle();
        en = 9'h1FF; tick();

        // Event on the clearing edge of the same bit: set wins, no drop.
        ev_a = 9'h002; tick(); ev_a = '0; tick();
        chk("t5_chan_1", irq_if.irq_chan, 1);
        ev_a = 9'h002; irq_if.irq_ack = 1'b1; tick();
        ev_a = '0; irq_if.irq_ack = 1'b0;
        chk("t5_set_wins", A, 9'h1FD);
        chk("t5_no_drop", drop_cnt, 0);
        tick(); tick();
        chk("t5_reissue", irq_if.irq_chan, 1);
        ack_and_settle();

        // Saturating drop count while holding another channel.
        ev_b = 9'h001; tick(); ev_b = '0; tick();
        ev_a = 9'h002;
        repeat (300) tick();
        ev_a = '0;
        chk("t5_drop_sat", drop_cnt, 255);
        chk("t5_pend_a1", A, 9'h1FD);
        chk("t5_frozen_level", irq_if.irq_level, 2);
        ack_and_settle(); tick();
        chk("t5_level_a", irq_if.irq_level, 1);
        ack_and_settle();

        // Reset during HOLD discards the interrupt.
        ev_c = 9'h004; tick(); ev_c = '0; tick();
        chk("t6_hold", irq_if.irq_valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_valid", irq_if.irq_valid, 0);
        chk("t6_level", irq_if.irq_level, 0);
        chk("t6_chan", irq_if.irq_chan, 0);
        chk("t6_code", irq_if.irq_code, 0);
        chk("t6_C", C, 9'h1FF);
        chk("t6_E", E, 9'h000);
        chk("t6_drop", drop_cnt, 0);
        irq_if.irq_ack = 1'b1; tick(); irq_if.irq_ack = 1'b0;
        chk("t6_ack_ignored", irq_if.irq_valid, 0);
        tick();

        // Random traffic.
        repeat (2500) begin
            ev_a = ($urandom_range(0, 5) == 0) ? 9'($urandom) : 9'h000;
            ev_b = ($urandom_range(0, 5) == 0) ? 9'($urandom) : 9'h000;
            ev_c = ($urandom_range(0, 5) == 0) ? 9'($urandom) : 9'h000;
            if ($urandom_range(0, 49) == 0) en = 9'($urandom);
            Chan = 4'($urandom);
            irq_if.irq_ack = ($urandom_range(0, 2) == 0);
            spur = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; ev_a = '0; ev_b = '0; ev_c = '0; spur = '0; irq_if.irq_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
